// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller: CSR map, cause codes,
// CSR write modes, FSM states and the read-modify-write helper.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam logic [4:0] CAUSE_ILLEGAL     = 5'd2;
    localparam logic [4:0] CAUSE_LOAD_FAULT  = 5'd5;
    localparam logic [4:0] CAUSE_STORE_FAULT = 5'd7;
    localparam logic [4:0] CAUSE_ECALL_M     = 5'd11;
    localparam logic [4:0] CAUSE_IRQ_BASE    = 5'd16;

    typedef enum logic [1:0] {
        WSC_NONE  = 2'b00,
        WSC_WRITE = 2'b01,
        WSC_SET   = 2'b10,
        WSC_CLEAR = 2'b11
    } wsc_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } trap_state_e;

    function automatic logic [31:0] csr_apply(input wsc_mode_e mode,
                                              input logic [31:0] old_val,
                                              input logic [31:0] d);
        case (mode)
            WSC_WRITE: csr_apply = d;
            WSC_SET:   csr_apply = old_val | d;
            WSC_CLEAR: csr_apply = old_val & ~d;
            default:   csr_apply = old_val;
        endcase
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR access bus between the MEM stage (master) and the trap controller (slave).
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    logic            csr_rw_in;
    logic [1:0]      csr_wsc_mode_in;
    logic            csr_w_imm_mux;
    logic [11:0]     csr_rw_addr_in;
    logic [XLEN-1:0] csr_w_data_reg;
    logic [4:0]      csr_w_data_imm;
    logic [XLEN-1:0] csr_r_data_out;

    modport master (
        output csr_rw_in, csr_wsc_mode_in, csr_w_imm_mux, csr_rw_addr_in,
               csr_w_data_reg, csr_w_data_imm,
        input  csr_r_data_out
    );

    modport slave (
        input  csr_rw_in, csr_wsc_mode_in, csr_w_imm_mux, csr_rw_addr_in,
               csr_w_data_reg, csr_w_data_imm,
        output csr_r_data_out
    );
endinterface

// File: rtl/trap_csr_file.sv
// Machine-mode CSR storage with combinational read mux, write/set/clear update
// and trap/mret side effects on mstatus, mepc, mcause and mtval.
module trap_csr_file
    import trap_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              NUM_IRQ   = 4,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               csr_we,
    input  wsc_mode_e          csr_mode,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    input  logic               trap_take,
    input  logic [XLEN-1:0]    trap_cause,
    input  logic [XLEN-1:0]    trap_epc,
    input  logic [XLEN-1:0]    trap_tval,
    input  logic               mret_take,
    input  logic [NUM_IRQ-1:0] mip_irq,
    output logic               mstatus_mie,
    output logic [NUM_IRQ-1:0] mie_irq,
    output logic [XLEN-1:0]    mtvec,
    output logic [XLEN-1:0]    mepc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic               mie_q, mpie_q;
    logic [NUM_IRQ-1:0] mie_en_q;
    logic [XLEN-1:0]    mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0]    mstatus_rd, mie_rd, mip_rd, new_val;

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mpie_q;
        mstatus_rd[3]     = mie_q;
        mie_rd            = '0;
        mie_rd[16 +: NUM_IRQ] = mie_en_q;
        mip_rd            = '0;
        mip_rd[16 +: NUM_IRQ] = mip_irq;
        case (csr_addr)
            CSR_MSTATUS:  csr_rdata = mstatus_rd;
            CSR_MIE:      csr_rdata = mie_rd;
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MTVAL:    csr_rdata = mtval_q;
            CSR_MIP:      csr_rdata = mip_rd;
            default:      csr_rdata = '0;
        endcase
        new_val = csr_apply(csr_mode, csr_rdata, csr_wdata);
    end

    // Trap entry outranks mret, which outranks an ordinary CSR instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mie_en_q   <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_take) begin
            mepc_q   <= trap_epc & ALIGN_MASK;
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret_take) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_q  <= new_val[3];
                    mpie_q <= new_val[7];
                end
                CSR_MIE:      mie_en_q   <= new_val[16 +: NUM_IRQ];
                // Reserved modes 2/3 leave the previous mode in place.
                CSR_MTVEC:    mtvec_q    <= new_val[1] ? {new_val[XLEN-1:2], mtvec_q[1:0]} : new_val;
                CSR_MSCRATCH: mscratch_q <= new_val;
                CSR_MEPC:     mepc_q     <= new_val & ALIGN_MASK;
                CSR_MCAUSE:   mcause_q   <= new_val;
                CSR_MTVAL:    mtval_q    <= new_val;
                default:      ;
            endcase
        end
    end

    assign mstatus_mie = mie_q;
    assign mie_irq     = mie_en_q;
    assign mtvec       = mtvec_q;
    assign mepc        = mepc_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: interrupt synchroniser, exception/interrupt
// priority, pipeline flush/cancel and a one-cycle registered PC redirect.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              NUM_IRQ   = 4,
    parameter logic [XLEN-1:0] MTVEC_RST = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    trap_ctrl_if.slave         csr,
    input  logic               mem_valid,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               illegal_inst,
    input  logic               l_access_fault,
    input  logic               s_access_fault,
    input  logic               ecall_m,
    input  logic               mret,
    input  logic [XLEN-1:0]    einst,
    input  logic [XLEN-1:0]    eaddr,
    input  logic [XLEN-1:0]    epc_cur,
    output logic [XLEN-1:0]    PC_redirect,
    output logic               redirect_mux,
    output logic               reg_FD_flush,
    output logic               reg_DE_flush,
    output logic               reg_EM_flush,
    output logic               reg_MW_flush,
    output logic               RegWrite_cancel,
    output logic               MemWrite_cancel,
    output logic               irq_taken,
    output logic [3:0]         irq_id
);

    logic [NUM_IRQ-1:0] irq_p0, irq_p1, irq_active, mie_irq;
    trap_state_e        state_q, state_d;
    logic               idle, irq_take, exc_take, trap_take, mret_take, mstatus_mie, csr_we;
    logic [3:0]         irq_idx;
    logic [4:0]         code;
    logic [XLEN-1:0]    trap_cause, trap_tval, trap_target, next_target;
    logic [XLEN-1:0]    mtvec, mepc, mtvec_base, csr_wdata;
    logic [XLEN-1:0]    target_p1;
    logic               irq_taken_p1;
    logic [3:0]         irq_id_p1;

    // Stage p0/p1: two-flop synchroniser for the asynchronous interrupt lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_p0 <= '0;
            irq_p1 <= '0;
        end else begin
            irq_p0 <= irq_in;
            irq_p1 <= irq_p0;
        end
    end

    assign idle       = (state_q == ST_IDLE);
    assign irq_active = irq_p1 & mie_irq;
    assign irq_take   = idle & mem_valid & mstatus_mie & (|irq_active);
    assign exc_take   = idle & mem_valid & (illegal_inst | l_access_fault | s_access_fault | ecall_m);
    assign trap_take  = irq_take | exc_take;
    assign mret_take  = idle & mem_valid & mret & ~trap_take;
    assign mtvec_base = {mtvec[XLEN-1:2], 2'b00};

    always_comb begin
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_active[i]) irq_idx = 4'(i);
        end
        code      = '0;
        trap_tval = '0;
        if (irq_take) begin
            code = CAUSE_IRQ_BASE + 5'(irq_idx);
        end else if (illegal_inst) begin
            code      = CAUSE_ILLEGAL;
            trap_tval = einst;
        end else if (ecall_m) begin
            code = CAUSE_ECALL_M;
        end else if (s_access_fault) begin
            code      = CAUSE_STORE_FAULT;
            trap_tval = eaddr;
        end else if (l_access_fault) begin
            code      = CAUSE_LOAD_FAULT;
            trap_tval = eaddr;
        end
        trap_cause            = '0;
        trap_cause[XLEN-1]    = irq_take;
        trap_cause[4:0]       = code;
        trap_target = (irq_take && mtvec[1:0] == 2'b01) ? mtvec_base + XLEN'({code, 2'b00})
                                                        : mtvec_base;
        next_target = trap_take ? trap_target : mepc;
    end

    assign csr_we    = csr.csr_rw_in & (csr.csr_wsc_mode_in != WSC_NONE) & ~trap_take;
    assign csr_wdata = csr.csr_w_imm_mux ? XLEN'(csr.csr_w_data_imm) : csr.csr_w_data_reg;

    trap_csr_file #(
        .XLEN      (XLEN),
        .NUM_IRQ   (NUM_IRQ),
        .MTVEC_RST (MTVEC_RST)
    ) u_csr (
        .clk         (clk),
        .rst         (rst),
        .csr_we      (csr_we),
        .csr_mode    (wsc_mode_e'(csr.csr_wsc_mode_in)),
        .csr_addr    (csr.csr_rw_addr_in),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr.csr_r_data_out),
        .trap_take   (trap_take),
        .trap_cause  (trap_cause),
        .trap_epc    (epc_cur),
        .trap_tval   (trap_tval),
        .mret_take   (mret_take),
        .mip_irq     (irq_p1),
        .mstatus_mie (mstatus_mie),
        .mie_irq     (mie_irq),
        .mtvec       (mtvec),
        .mepc        (mepc)
    );

    always_comb begin
        state_d         = state_q;
        reg_FD_flush    = 1'b0;
        reg_DE_flush    = 1'b0;
        reg_EM_flush    = 1'b0;
        reg_MW_flush    = 1'b0;
        RegWrite_cancel = 1'b0;
        MemWrite_cancel = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trap_take || mret_take) state_d = ST_REDIR;
                reg_FD_flush    = trap_take | mret_take;
                reg_DE_flush    = trap_take | mret_take;
                reg_EM_flush    = trap_take | mret_take;
                reg_MW_flush    = trap_take;
                RegWrite_cancel = trap_take;
                MemWrite_cancel = trap_take;
            end
            ST_REDIR: begin
                state_d      = ST_IDLE;
                reg_FD_flush = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage p1: registered redirect target and interrupt acknowledge
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            target_p1    <= '0;
            irq_taken_p1 <= 1'b0;
            irq_id_p1    <= '0;
        end else begin
            state_q      <= state_d;
            target_p1    <= (trap_take | mret_take) ? next_target : '0;
            irq_taken_p1 <= irq_take;
            irq_id_p1    <= irq_take ? irq_idx : 4'd0;
        end
    end

    assign redirect_mux = (state_q == ST_REDIR);
    assign PC_redirect  = target_p1;
    assign irq_taken    = irq_taken_p1;
    assign irq_id       = irq_id_p1;

endmodule
